// File: rtl/bcd_pkg.sv
// Shared types and constants for the time-shared binary-to-BCD converter.
package bcd_pkg;

  typedef enum logic {IDLE, SHIFT} state_e;

  localparam int           DIGIT_W     = 4;
  localparam logic [3:0]   ADD3_THRESH = 4'd5;
  localparam logic [3:0]   DIGIT_NINE  = 4'h9;

endpackage

// File: rtl/bcd_digit_cell.sv
// One double-dabble digit slice: add-3 correction followed by a one-bit left shift.
module bcd_digit_cell
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] dig,
  input  logic               sin,
  output logic [DIGIT_W-1:0] nxt,
  output logic               cout
);

  logic [DIGIT_W-1:0] adj;

  assign adj  = (dig >= ADD3_THRESH) ? dig + DIGIT_W'(3) : dig;
  assign nxt  = {adj[DIGIT_W-2:0], sin};
  assign cout = adj[DIGIT_W-1];

endmodule

// File: rtl/bcd_conv_arbiter.sv
// Round-robin shared binary-to-BCD engine, one bit per clock (double dabble).
// Build option: define BCD_SAT_EN to saturate out-of-range results to all nines.
module bcd_conv_arbiter
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 24,
  parameter int DIGITS = 7
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  req0_i,
  input  logic                  req1_i,
  input  logic [BIN_W-1:0]      bin0_i,
  input  logic [BIN_W-1:0]      bin1_i,
  output logic                  ack0_o,
  output logic                  ack1_o,
  output logic                  busy_o,
  output logic [4*DIGITS-1:0]   bcd_o,
  output logic                  valid_o,
  output logic                  id_o,
  output logic                  ovf_o
);

  localparam int CW = $clog2(BIN_W);

  state_e                           state_q, state_d;
  logic [CW-1:0]                    cnt_q;
  logic [BIN_W-1:0]                 bin_q;
  logic [DIGITS-1:0][DIGIT_W-1:0]   dig_q, dig_nxt;
  logic [DIGITS:0]                  chain;
  logic                             last_grant;
  logic                             cap, fin, win;

  // Serial chain: binary MSB feeds digit 0, each digit's carry feeds the next.
  assign chain[0] = bin_q[BIN_W-1];

  for (genvar g = 0; g < DIGITS; g++) begin : g_cell
    bcd_digit_cell u_cell (
      .dig  (dig_q[g]),
      .sin  (chain[g]),
      .nxt  (dig_nxt[g]),
      .cout (chain[g+1])
    );
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    cap     = 1'b0;
    fin     = 1'b0;
    win     = 1'b0;
    case (state_q)
      IDLE: if (req0_i || req1_i) begin
        cap     = 1'b1;
        // On a tie the requester that did not win last time gets the slot.
        win     = req1_i && (!req0_i || !last_grant);
        state_d = SHIFT;
      end
      SHIFT: if (cnt_q == '0) begin
        fin     = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q      <= '0;
      bin_q      <= '0;
      dig_q      <= '0;
      last_grant <= 1'b1;
      ack0_o     <= 1'b0;
      ack1_o     <= 1'b0;
      busy_o     <= 1'b0;
      valid_o    <= 1'b0;
      id_o       <= 1'b0;
    end else begin
      ack0_o  <= cap && !win;
      ack1_o  <= cap && win;
      valid_o <= fin;
      if (cap) begin
        bin_q      <= win ? bin1_i : bin0_i;
        dig_q      <= '0;
        cnt_q      <= CW'(BIN_W - 1);
        last_grant <= win;
        busy_o     <= 1'b1;
      end else if (state_q == SHIFT) begin
        bin_q  <= {bin_q[BIN_W-2:0], 1'b0};
        dig_q  <= dig_nxt;
        cnt_q  <= cnt_q - CW'(1);
        if (fin) begin
          busy_o <= 1'b0;
          id_o   <= last_grant;
        end
      end
    end
  end

`ifdef BCD_SAT_EN
  logic flag_q, flag_nxt;

  // Sticky: any bit leaving the top digit means the value needs more digits.
  assign flag_nxt = flag_q | chain[DIGITS];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      flag_q <= 1'b0;
      bcd_o  <= '0;
      ovf_o  <= 1'b0;
    end else if (cap) begin
      flag_q <= 1'b0;
    end else if (state_q == SHIFT) begin
      flag_q <= flag_nxt;
      if (fin) begin
        bcd_o <= flag_nxt ? {DIGITS{DIGIT_NINE}} : dig_nxt;
        ovf_o <= flag_nxt;
      end
    end
  end
`else
  logic unused_top_carry;
  assign unused_top_carry = chain[DIGITS];
  assign ovf_o            = 1'b0;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)  bcd_o <= '0;
    else if (fin) bcd_o <= dig_nxt;
  end
`endif

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Self-checking bench for bcd_conv_arbiter: directed table, random values, arbitration/reset sequences.
module tb_bcd_conv_arbiter;

  localparam int BIN_W  = 24;
  localparam int DIGITS = 7;

  logic clk = 1'b0, resetn = 1'b0;
  logic req0 = 1'b0, req1 = 1'b0;
  logic [BIN_W-1:0] bin0 = '0, bin1 = '0;
  logic ack0, ack1, busy, valid, id, ovf;
  logic [4*DIGITS-1:0] bcd;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bcd_conv_arbiter #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
    .clk(clk), .resetn(resetn),
    .req0_i(req0), .req1_i(req1), .bin0_i(bin0), .bin1_i(bin1),
    .ack0_o(ack0), .ack1_o(ack1), .busy_o(busy),
    .bcd_o(bcd), .valid_o(valid), .id_o(id), .ovf_o(ovf)
  );

`ifdef BCD_SAT_EN
  localparam logic SAT = 1'b1;
`else
  localparam logic SAT = 1'b0;
`endif

  typedef struct {
    logic             sel;
    logic [BIN_W-1:0] val;
    logic [27:0]      exp_bcd;
    logic             exp_ovf;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: decimal digits by division; out-of-range handled by the build option.
  task automatic model(input int unsigned v, output logic [27:0] b, output logic o);
    int unsigned r = v;
    b = '0;
    for (int k = 0; k < DIGITS; k++) begin
      b[4*k +: 4] = 4'(r % 10);
      r = r / 10;
    end
    o = 1'b0;
    if (SAT && v > 9999999) begin
      b = 28'h9999999;
      o = 1'b1;
    end
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk); #1;
  endtask

  // One full transaction from a single requester; called #1 after a rising edge.
  task automatic run_one(input logic sel, input logic [BIN_W-1:0] val,
                         input logic [27:0] eb, input logic eo, input string nm);
    bit got = 0;
    bit side = 0;
    int n = 0;
    if (sel) begin bin1 = val; req1 = 1'b1; end
    else     begin bin0 = val; req0 = 1'b1; end
    for (int i = 0; i < 4 && !got; i++) begin
      @(posedge clk); #1;
      if (ack0 || ack1) got = 1;
    end
    chk({nm, " ack"}, {30'd0, ack1, ack0}, sel ? 32'd2 : 32'd1);
    req0 = 1'b0;
    req1 = 1'b0;
    if (!got) return;
    if (!busy) side = 1;
    got = 0;
    while (!got && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (valid) got = 1;
      else if (!busy || ack0 || ack1) side = 1;
    end
    chk({nm, " latency"}, n, BIN_W);
    chk({nm, " busy/ack"}, {31'd0, side}, 0);
    chk({nm, " busy at valid"}, {31'd0, busy}, 0);
    chk({nm, " bcd"}, {4'd0, bcd}, {4'd0, eb});
    chk({nm, " id"}, {31'd0, id}, {31'd0, sel});
    chk({nm, " ovf"}, {31'd0, ovf}, {31'd0, eo});
  endtask

  initial begin
    vec_t vecs[$];
    bit got;
    int n;
    logic [27:0] eb;
    logic eo;

    vecs.push_back('{1'b0, 24'd1234567,  28'h1234567, 1'b0});
    vecs.push_back('{1'b0, 24'd0,        28'h0000000, 1'b0});
    vecs.push_back('{1'b0, 24'd9999999,  28'h9999999, 1'b0});
    vecs.push_back('{1'b0, 24'd16777215, SAT ? 28'h9999999 : 28'h6777215, SAT});
    vecs.push_back('{1'b1, 24'd10000000, SAT ? 28'h9999999 : 28'h0000000, SAT});
    vecs.push_back('{1'b1, 24'd5,        28'h0000005, 1'b0});
    vecs.push_back('{1'b1, 24'd8005009,  28'h8005009, 1'b0});
    vecs.push_back('{1'b0, 24'd1,        28'h0000001, 1'b0});

    do_reset();
    chk("reset bcd",   {4'd0, bcd}, 0);
    chk("reset valid", {31'd0, valid}, 0);
    chk("reset id",    {31'd0, id}, 0);
    chk("reset ovf",   {31'd0, ovf}, 0);
    chk("reset acks",  {30'd0, ack1, ack0}, 0);
    chk("reset busy",  {31'd0, busy}, 0);

    // Tie right after reset: requester 0 first, requester 1 captured at the edge ending valid.
    bin0 = 24'd42; bin1 = 24'd9999999;
    req0 = 1'b1;   req1 = 1'b1;
    got = 0;
    for (int i = 0; i < 4 && !got; i++) begin
      @(posedge clk); #1;
      if (ack0 || ack1) got = 1;
    end
    chk("tie first ack", {30'd0, ack1, ack0}, 1);
    req0 = 1'b0;
    got = 0; n = 0;
    while (!got && n < 40) begin
      @(posedge clk); #1; n++;
      if (valid) got = 1;
    end
    chk("tie first latency", n, BIN_W);
    chk("tie first id",  {31'd0, id}, 0);
    chk("tie first bcd", {4'd0, bcd}, 32'h0000042);
    @(posedge clk); #1;
    chk("tie second ack", {30'd0, ack1, ack0}, 2);
    req1 = 1'b0;
    n = 1; got = 0;
    while (!got && n < 40) begin
      @(posedge clk); #1; n++;
      if (valid) got = 1;
    end
    chk("tie spacing", n, BIN_W + 1);
    chk("tie second id",  {31'd0, id}, 1);
    chk("tie second bcd", {4'd0, bcd}, 32'h9999999);

    // Held request: req1 stays high through its conversion.
    bin1 = 24'd314159; req1 = 1'b1;
    got = 0;
    for (int i = 0; i < 4 && !got; i++) begin
      @(posedge clk); #1;
      if (ack1) got = 1;
    end
    chk("held first ack", {31'd0, ack1}, 1);
    got = 0; n = 0;
    while (!got && n < 40) begin
      @(posedge clk); #1; n++;
      if (valid) got = 1;
    end
    chk("held bcd", {4'd0, bcd}, 32'h0314159);
    @(posedge clk); #1;
    chk("held re-ack", {30'd0, ack1, ack0}, 2);
    req1 = 1'b0;
    repeat (BIN_W + 2) @(posedge clk);
    #1;

    foreach (vecs[i]) run_one(vecs[i].sel, vecs[i].val, vecs[i].exp_bcd, vecs[i].exp_ovf, $sformatf("vec%0d", i));

    for (int i = 0; i < 16; i++) begin
      logic [BIN_W-1:0] v;
      logic s;
      v = BIN_W'($urandom_range(0, 16777215));
      if (i % 4 == 0) v = BIN_W'($urandom_range(0, 9999));
      s = 1'($urandom_range(0, 1));
      model(32'(v), eb, eo);
      run_one(s, v, eb, eo, $sformatf("rnd%0d", i));
    end

    // Reset in the middle of a conversion.
    bin0 = 24'd7654321; req0 = 1'b1;
    got = 0;
    for (int i = 0; i < 4 && !got; i++) begin
      @(posedge clk); #1;
      if (ack0) got = 1;
    end
    chk("midrst ack", {31'd0, ack0}, 1);
    req0 = 1'b0;
    repeat (10) @(posedge clk);
    #2 resetn = 1'b0;
    #1;
    chk("midrst bcd",   {4'd0, bcd}, 0);
    chk("midrst busy",  {31'd0, busy}, 0);
    chk("midrst valid", {31'd0, valid}, 0);
    chk("midrst id/ovf/acks", {28'd0, id, ovf, ack1, ack0}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    got = 0;
    for (int i = 0; i < BIN_W + 6; i++) begin
      @(posedge clk); #1;
      if (valid || busy) got = 1;
    end
    chk("midrst no valid", {31'd0, got}, 0);
    run_one(1'b1, 24'd777, 28'h0000777, 1'b0, "post-reset req1");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
